// File: rtl/move_entry_conditioner.sv
// Input conditioner for the tic-tac-toe game FSM. It synchronizes the move switches and both
// buttons, debounces the buttons, and forwards only ENTER presses that carry a legal move (1..9).
module move_entry_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic       clock,
  input  logic       reset_L,
  input  logic [3:0] hMoveSw,
  input  logic       enterRaw_L,
  input  logic       newGameRaw_L,
  output logic [3:0] hMove,
  output logic       enter_L,
  output logic       newGame_L,
  output logic       badMove
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES);
  localparam logic [CntW-1:0] CntOne = CntW'(1);

  // Button channel indices into the per-button arrays.
  localparam int unsigned Enter   = 0;
  localparam int unsigned NewGame = 1;

  typedef enum logic [1:0] {
    StUp,
    StDnPend,
    StDown,
    StUpPend
  } db_state_e;

  // Two-flop synchronizers. Buttons idle high, switches idle low.
  logic [3:0] sw_s1_q, sw_s2_q;
  logic [1:0] btn_s1_q, btn_s2_q;

  // Debouncer state per button.
  db_state_e       db_state_q [2];
  db_state_e       db_state_d [2];
  logic [CntW-1:0] db_cnt_q   [2];
  logic [CntW-1:0] db_cnt_d   [2];
  logic [CntW-1:0] cnt_inc    [2];
  logic [1:0]      press_ev;
  logic [1:0]      release_ev;

  // Output registers.
  logic [3:0] hmove_q, hmove_d;
  logic       enter_q, enter_d;
  logic       newgame_q, newgame_d;
  logic       bad_q, bad_d;
  logic       move_legal;

  // Synchronizer flops for all raw inputs.
  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      sw_s1_q  <= 4'd0;
      sw_s2_q  <= 4'd0;
      btn_s1_q <= 2'b11;
      btn_s2_q <= 2'b11;
    end else begin
      sw_s1_q  <= hMoveSw;
      sw_s2_q  <= sw_s1_q;
      btn_s1_q <= {newGameRaw_L, enterRaw_L};
      btn_s2_q <= btn_s1_q;
    end
  end

  // Debouncer next state: a level flips only after DEBOUNCE_CYCLES consecutive opposite samples.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      db_state_d[i] = db_state_q[i];
      db_cnt_d[i]   = db_cnt_q[i];
      cnt_inc[i]    = db_cnt_q[i] + CntOne;
      press_ev[i]   = 1'b0;
      release_ev[i] = 1'b0;
      unique case (db_state_q[i])
        StUp: begin
          if (!btn_s2_q[i]) begin
            // A one-cycle debounce settles on the very first opposite sample.
            if (CntOne == CntMax) begin
              db_state_d[i] = StDown;
              press_ev[i]   = 1'b1;
            end else begin
              db_state_d[i] = StDnPend;
              db_cnt_d[i]   = CntOne;
            end
          end
        end
        StDnPend: begin
          if (btn_s2_q[i]) begin
            db_state_d[i] = StUp;
            db_cnt_d[i]   = '0;
          end else if (cnt_inc[i] == CntMax) begin
            db_state_d[i] = StDown;
            db_cnt_d[i]   = '0;
            press_ev[i]   = 1'b1;
          end else begin
            db_cnt_d[i]   = cnt_inc[i];
          end
        end
        StDown: begin
          if (btn_s2_q[i]) begin
            if (CntOne == CntMax) begin
              db_state_d[i] = StUp;
              release_ev[i] = 1'b1;
            end else begin
              db_state_d[i] = StUpPend;
              db_cnt_d[i]   = CntOne;
            end
          end
        end
        StUpPend: begin
          if (!btn_s2_q[i]) begin
            db_state_d[i] = StDown;
            db_cnt_d[i]   = '0;
          end else if (cnt_inc[i] == CntMax) begin
            db_state_d[i] = StUp;
            db_cnt_d[i]   = '0;
            release_ev[i] = 1'b1;
          end else begin
            db_cnt_d[i]   = cnt_inc[i];
          end
        end
        default: begin
          db_state_d[i] = StUp;
          db_cnt_d[i]   = '0;
        end
      endcase
    end
  end

  // Debouncer state registers.
  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      for (int i = 0; i < 2; i++) begin
        db_state_q[i] <= StUp;
        db_cnt_q[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        db_state_q[i] <= db_state_d[i];
        db_cnt_q[i]   <= db_cnt_d[i];
      end
    end
  end

  assign move_legal = (sw_s2_q != 4'd0) && (sw_s2_q <= 4'd9);

  // Output next state: ENTER is qualified by the move value, NEW GAME passes straight through.
  always_comb begin
    hmove_d = hmove_q;
    enter_d = enter_q;
    bad_d   = bad_q;
    if (press_ev[Enter]) begin
      if (move_legal) begin
        hmove_d = sw_s2_q;
        bad_d   = 1'b0;
        enter_d = 1'b0;
      end else begin
        // Illegal move: swallow the whole press so the game FSM never sees it.
        bad_d   = 1'b1;
      end
    end else if (release_ev[Enter]) begin
      enter_d = 1'b1;
    end
    newgame_d = !(db_state_d[NewGame] inside {StDown, StUpPend});
  end

  // Output registers.
  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      hmove_q   <= 4'd0;
      enter_q   <= 1'b1;
      newgame_q <= 1'b1;
      bad_q     <= 1'b0;
    end else begin
      hmove_q   <= hmove_d;
      enter_q   <= enter_d;
      newgame_q <= newgame_d;
      bad_q     <= bad_d;
    end
  end

  assign hMove     = hmove_q;
  assign enter_L   = enter_q;
  assign newGame_L = newgame_q;
  assign badMove   = bad_q;

endmodule

// File: tb/tb_move_entry_conditioner.sv
// Scoreboard bench for move_entry_conditioner with DEBOUNCE_CYCLES=4.
module tb_move_entry_conditioner;

  localparam int unsigned N = 4;

  logic       clock = 1'b0;
  logic       reset_L = 1'b0;
  logic [3:0] hMoveSw = 4'd0;
  logic       enterRaw_L = 1'b1;
  logic       newGameRaw_L = 1'b1;
  logic [3:0] hMove;
  logic       enter_L;
  logic       newGame_L;
  logic       badMove;

  move_entry_conditioner #(
    .DEBOUNCE_CYCLES(N)
  ) dut (
    .clock       (clock),
    .reset_L     (reset_L),
    .hMoveSw     (hMoveSw),
    .enterRaw_L  (enterRaw_L),
    .newGameRaw_L(newGameRaw_L),
    .hMove       (hMove),
    .enter_L     (enter_L),
    .newGame_L   (newGame_L),
    .badMove     (badMove)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int passes = 0;

  // Expected {hMove, enter_L, newGame_L, badMove} per rising edge.
  logic [6:0] exp_q[$];

  // Reference model: inputs reach the debouncers two edges after being sampled; a level flips
  // when the last N samples seen all disagree with it.
  logic [3:0] m_sw_pipe [2];
  bit         m_en_pipe [2];
  bit         m_ng_pipe [2];
  bit [N-1:0] m_en_hist;
  bit [N-1:0] m_ng_hist;
  bit         m_en_lvl;
  bit         m_ng_lvl;
  logic [3:0] m_hmove;
  bit         m_enter;
  bit         m_bad;

  task automatic model_reset();
    m_sw_pipe[0] = 4'd0;
    m_sw_pipe[1] = 4'd0;
    m_en_pipe[0] = 1'b1;
    m_en_pipe[1] = 1'b1;
    m_ng_pipe[0] = 1'b1;
    m_ng_pipe[1] = 1'b1;
    m_en_hist    = '1;
    m_ng_hist    = '1;
    m_en_lvl     = 1'b1;
    m_ng_lvl     = 1'b1;
    m_hmove      = 4'd0;
    m_enter      = 1'b1;
    m_bad        = 1'b0;
  endtask

  task automatic model_step();
    logic [3:0] s_sw;
    bit         s_en;
    bit         s_ng;
    s_sw = m_sw_pipe[1];
    s_en = m_en_pipe[1];
    s_ng = m_ng_pipe[1];
    m_sw_pipe[1] = m_sw_pipe[0];
    m_sw_pipe[0] = hMoveSw;
    m_en_pipe[1] = m_en_pipe[0];
    m_en_pipe[0] = enterRaw_L;
    m_ng_pipe[1] = m_ng_pipe[0];
    m_ng_pipe[0] = newGameRaw_L;

    m_en_hist = {m_en_hist[N-2:0], s_en};
    m_ng_hist = {m_ng_hist[N-2:0], s_ng};

    if (m_en_lvl && m_en_hist == '0) begin
      m_en_lvl = 1'b0;
      if (s_sw >= 4'd1 && s_sw <= 4'd9) begin
        m_hmove = s_sw;
        m_bad   = 1'b0;
        m_enter = 1'b0;
      end else begin
        m_bad   = 1'b1;
      end
    end else if (!m_en_lvl && m_en_hist == '1) begin
      m_en_lvl = 1'b1;
      m_enter  = 1'b1;
    end

    if (m_ng_lvl && m_ng_hist == '0) m_ng_lvl = 1'b0;
    else if (!m_ng_lvl && m_ng_hist == '1) m_ng_lvl = 1'b1;
  endtask

  // Model process: one expected tuple per rising edge.
  initial begin
    model_reset();
    forever begin
      @(posedge clock);
      if (!reset_L) model_reset();
      else model_step();
      exp_q.push_back({m_hmove, m_enter, m_ng_lvl, m_bad});
    end
  end

  // Monitor: compare DUT outputs shortly after each rising edge.
  initial begin
    logic [6:0] e;
    logic [6:0] got;
    forever begin
      @(posedge clock);
      #2;
      got = {hMove, enter_L, newGame_L, badMove};
      checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL scoreboard_empty t=%0t got=%h required=an expected entry", $time, got);
      end else begin
        e = exp_q.pop_front();
        if (got === e) begin
          passes++;
        end else begin
          $display("FAIL outputs t=%0t got hMove=%0d enter_L=%b newGame_L=%b badMove=%b required hMove=%0d enter_L=%b newGame_L=%b badMove=%b",
                   $time, got[6:3], got[2], got[1], got[0], e[6:3], e[2], e[1], e[0]);
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic press(input logic [3:0] sw, input int hold, input int rel);
    hMoveSw    = sw;
    enterRaw_L = 1'b0;
    cyc(hold);
    enterRaw_L = 1'b1;
    cyc(rel);
  endtask

  // Stimulus.
  initial begin
    logic [6:0] got;
    reset_L = 1'b0;
    cyc(3);
    reset_L = 1'b1;
    cyc(4);

    // Clean press with a legal move.
    press(4'd6, 20, 15);

    // Bouncing press, then a stable hold.
    hMoveSw = 4'd2;
    enterRaw_L = 1'b0; cyc(2);
    enterRaw_L = 1'b1; cyc(2);
    enterRaw_L = 1'b0; cyc(2);
    enterRaw_L = 1'b1; cyc(2);
    enterRaw_L = 1'b0; cyc(15);
    enterRaw_L = 1'b1; cyc(15);

    // Out-of-range moves are swallowed, then a legal 9.
    press(4'd0, 15, 15);
    press(4'd12, 15, 15);
    press(4'd9, 15, 15);

    // Switch change while held is ignored until the next press.
    hMoveSw = 4'd3;
    enterRaw_L = 1'b0; cyc(10);
    hMoveSw = 4'd7; cyc(10);
    enterRaw_L = 1'b1; cyc(15);
    press(4'd7, 12, 15);

    // Simultaneous ENTER and NEW GAME.
    hMoveSw = 4'd4;
    enterRaw_L = 1'b0;
    newGameRaw_L = 1'b0;
    cyc(15);
    enterRaw_L = 1'b1;
    newGameRaw_L = 1'b1;
    cyc(15);

    // Reset while a legal press is active and the button is still held.
    hMoveSw = 4'd5;
    enterRaw_L = 1'b0;
    cyc(12);
    reset_L = 1'b0;
    #1;
    got = {hMove, enter_L, newGame_L, badMove};
    checks++;
    if (got === {4'd0, 1'b1, 1'b1, 1'b0}) passes++;
    else $display("FAIL async_reset got hMove=%0d enter_L=%b newGame_L=%b badMove=%b required 0 1 1 0",
                  got[6:3], got[2], got[1], got[0]);
    cyc(3);
    reset_L = 1'b1;
    cyc(15);
    enterRaw_L = 1'b1;
    cyc(15);

    // Randomized segments: mixes glitches shorter than the debounce window with real presses.
    for (int s = 0; s < 250; s++) begin
      enterRaw_L   = 1'($urandom_range(0, 1));
      newGameRaw_L = 1'($urandom_range(0, 1));
      hMoveSw      = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) cyc(int'($urandom_range(6, 14)));
      else cyc(int'($urandom_range(1, 5)));
    end
    enterRaw_L = 1'b1;
    newGameRaw_L = 1'b1;
    cyc(12);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
